// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioner: channel FSM encoding, default
// timing constants and bit positions of each sensor in the packed level vector.
package sensor_pkg;

  typedef enum logic {Hold, Confirm} chan_state_e;

  localparam int unsigned DefaultDiv    = 4;
  localparam int unsigned DefaultStable = 3;
  localparam int unsigned DefaultCw     = 4;

  localparam int unsigned HEAD    = 3;
  localparam int unsigned LEFT    = 2;
  localparam int unsigned UNDER   = 1;
  localparam int unsigned BARRIER = 0;

endpackage

// File: rtl/debounce_channel.sv
// One sensor bit: two-flop synchronizer followed by a tick-paced debounce FSM.
// LATCH makes a risen level sticky until reset.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int unsigned STABLE = DefaultStable,
  parameter int unsigned CW     = DefaultCw,
  parameter bit          LATCH  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic flip
);

  logic          s1_q, s2_q, level_q, flip_q;
  logic [CW-1:0] cnt_q;
  chan_state_e   state_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      flip_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= Hold;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      flip_q <= 1'b0;
      // A latched channel freezes entirely once its level is high.
      if (tick && !(LATCH && level_q)) begin
        unique case (state_q)
          Hold: begin
            if (s2_q != level_q) begin
              if (STABLE == 1) begin
                level_q <= ~level_q;
                flip_q  <= 1'b1;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= Confirm;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          Confirm: begin
            if (s2_q == level_q) begin
              cnt_q   <= '0;
              state_q <= Hold;
            end else if (cnt_q == CW'(STABLE - 1)) begin
              level_q <= ~level_q;
              flip_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= Hold;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign level = level_q;
  assign flip  = flip_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces the four robot sensors on a shared sample tick.
// Define UNDER_LATCH_EN to make the under sensor sticky-high until reset.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned DIV    = DefaultDiv,
  parameter int unsigned STABLE = DefaultStable,
  parameter int unsigned CW     = DefaultCw
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_head,
  input  logic raw_left,
  input  logic raw_under,
  input  logic raw_barrier,
  output logic head,
  output logic left,
  output logic under,
  output logic barrier,
  output logic changed
);

`ifdef UNDER_LATCH_EN
  localparam bit UnderLatch = 1'b1;
`else
  localparam bit UnderLatch = 1'b0;
`endif

  logic [CW-1:0] pre_q;
  logic          tick;
  logic [3:0]    raw_vec, level_vec, flip_vec;

  assign tick = (pre_q == CW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + CW'(1);
    end
  end

  always_comb begin
    raw_vec          = '0;
    raw_vec[HEAD]    = raw_head;
    raw_vec[LEFT]    = raw_left;
    raw_vec[UNDER]   = raw_under;
    raw_vec[BARRIER] = raw_barrier;
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    debounce_channel #(
      .STABLE (STABLE),
      .CW     (CW),
      .LATCH  (UnderLatch && (i == UNDER))
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .raw   (raw_vec[i]),
      .level (level_vec[i]),
      .flip  (flip_vec[i])
    );
  end

  assign head    = level_vec[HEAD];
  assign left    = level_vec[LEFT];
  assign under   = level_vec[UNDER];
  assign barrier = level_vec[BARRIER];
  // Flips are registered per channel, so simultaneous flips merge into one pulse.
  assign changed = |flip_vec;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: run-length reference model plus
// directed literal checks and randomized sensor traffic.
module tb_sensor_conditioner;

  localparam int unsigned DIV    = 4;
  localparam int unsigned STABLE = 3;
  localparam int unsigned CW     = 4;

`ifdef UNDER_LATCH_EN
  localparam bit Latch = 1'b1;
`else
  localparam bit Latch = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rv    = 4'b0000;  // {head, left, under, barrier}
  logic       head, left, under, barrier, changed;

  always #5 clock = ~clock;

  sensor_conditioner #(
    .DIV    (DIV),
    .STABLE (STABLE),
    .CW     (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_head    (rv[3]),
    .raw_left    (rv[2]),
    .raw_under   (rv[1]),
    .raw_barrier (rv[0]),
    .head        (head),
    .left        (left),
    .under       (under),
    .barrier     (barrier),
    .changed     (changed)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: raw reaches the filter two edges late; on each tick a channel counts
  // consecutive disagreeing samples and flips after STABLE of them.
  logic [3:0] m_d1, m_d2, m_out;
  logic       m_chg;
  int         m_run [4];
  int         m_edge;
  int         last_edge;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r);
    logic [3:0] samp;
    if (!rst) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_chg = 1'b0;
      for (int c = 0; c < 4; c++) m_run[c] = 0;
      m_edge    = 0;
      last_edge = -1;
    end else begin
      samp  = m_d2;
      m_d2  = m_d1;
      m_d1  = r;
      m_chg = 1'b0;
      if ((m_edge % DIV) == DIV - 1) begin
        for (int c = 0; c < 4; c++) begin
          if (!(Latch && c == 1 && m_out[c])) begin
            if (samp[c] != m_out[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == STABLE) begin
              m_out[c] = ~m_out[c];
              m_run[c] = 0;
              m_chg    = 1'b1;
            end
          end
        end
      end
      last_edge = m_edge;
      m_edge++;
    end
  endtask

  task automatic step();
    logic       rst;
    logic [3:0] r;
    rst = reset;
    r   = rv;
    @(posedge clock);
    model_edge(rst, r);
    #1;
    check("outputs_vs_model", int'({head, left, under, barrier, changed}),
          int'({m_out, m_chg}));
  endtask

  int pulses, el, eu;

  initial begin
    // Reset held with all sensors high.
    reset = 1'b0;
    rv    = 4'b1111;
    repeat (3) step();
    check("reset_outputs_zero", int'({head, left, under, barrier, changed}), 0);
    rv = 4'b0000;
    step();

    // Clean rise on head: ticks at edges 3, 7, 11.
    reset = 1'b1;
    step();                 // edge 0
    rv[3] = 1'b1;
    repeat (10) step();     // edges 1..10
    check("rise_head_e10", int'(head), 0);
    step();                 // edge 11
    check("rise_head_e11", int'(head), 1);
    check("rise_changed_e11", int'(changed), 1);
    check("model_pins_e11", last_edge, 11);
    step();
    check("rise_changed_e12", int'(changed), 0);

    // Five-cycle glitch on barrier never passes.
    pulses = 0;
    rv[0]  = 1'b1;
    repeat (5) begin step(); if (changed) pulses++; end
    rv[0] = 1'b0;
    repeat (30) begin step(); if (changed) pulses++; end
    check("glitch_barrier", int'(barrier), 0);
    check("glitch_no_changed", pulses, 0);

    // Left and under rise together.
    pulses = 0; el = -1; eu = -1;
    rv[2] = 1'b1;
    rv[1] = 1'b1;
    repeat (20) begin
      step();
      if (changed) pulses++;
      if (left && el < 0) el = last_edge;
      if (under && eu < 0) eu = last_edge;
    end
    check("simul_left", int'(left), 1);
    check("simul_under", int'(under), 1);
    check("simul_same_edge", el, eu);
    check("simul_one_pulse", pulses, 1);

    // Under released for 20 ticks.
    rv[1] = 1'b0;
    repeat (20 * DIV) step();
    check("under_after_release", int'(under), Latch ? 1 : 0);

    // Reset after the second disagreeing tick discards the count.
    reset = 1'b0;
    rv[3] = 1'b1;
    repeat (2) step();
    check("midconf_reset_head", int'(head), 0);
    reset = 1'b1;
    repeat (8) step();      // edges 0..7, two disagreeing ticks
    reset = 1'b0;
    step();
    check("midconf_head_in_reset", int'(head), 0);
    reset = 1'b1;
    repeat (11) step();     // edges 0..10
    check("midconf_head_e10", int'(head), 0);
    step();                 // edge 11
    check("midconf_head_e11", int'(head), 1);

    // Random sensor traffic with occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) rv[$urandom_range(0, 3)] ^= 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
